rle_flash_prefetch: RTL

//  Parametrised flash streaming front-end between spi_flash_controller and the RLE video decoder.

---
 rtl/rle_flash_prefetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rle_flash_prefetch.sv
// Flash streaming front-end: issues SPI start/continue/stop, buffers words in a prefetch FIFO, keeps replay slots.
// Latency: fetch_en in IDLE gives a start pulse after 1 cycle; out_valid rises 1 cycle after a word is captured.
// Backpressure: out_valid/out_ready; a new word is requested only when a FIFO entry is free, otherwise the read is parked.
module rle_flash_prefetch #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 24,
    parameter int FIFO_DEPTH       = 4,
    parameter int NUM_SLOTS        = 2,
    localparam int SLOT_BITS       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int DW              = 8 * DATA_WIDTH_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 stop,
    input  logic                 save_addr,
    input  logic                 load_addr,
    input  logic                 clear_addr,
    input  logic [SLOT_BITS-1:0] slot_sel,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] spi_addr,
    output logic                 spi_start_read,
    output logic                 spi_continue_read,
    output logic                 spi_stop_read,
    input  logic [DW-1:0]        spi_data,
    input  logic                 spi_busy
);

    localparam int BYTE_SH = $clog2(DATA_WIDTH_BYTES);
    localparam int WAB     = ADDR_BITS - BYTE_SH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, REQ_S, REQ_C, WAIT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_after;
    logic [WAB-1:0]   fetch_addr, cons_addr;
    logic [WAB-1:0]   slot [NUM_SLOTS];
    logic             slot_ok, load_eff, flush, push, pop, full;

    // Out-of-range slot indices make save and load no-ops.
    assign slot_ok   = (32'(slot_sel) < 32'(NUM_SLOTS));
    assign load_eff  = load_addr && slot_ok;
    assign flush     = stop || load_eff || clear_addr;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    // A flush cycle discards both the arriving word and any pop.
    assign pop       = out_valid && out_ready && !flush;
    assign push      = (state == WAIT) && !spi_busy && !flush;
    assign count_after = count + (PTR_W+1)'(1) - (PTR_W+1)'(pop);
    assign spi_addr  = ADDR_BITS'(fetch_addr) << BYTE_SH;

    // State register plus registered request/stop pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            spi_start_read    <= 1'b0;
            spi_continue_read <= 1'b0;
            spi_stop_read     <= 1'b0;
        end else begin
            state             <= state_nxt;
            spi_start_read    <= (state_nxt == REQ_S);
            spi_continue_read <= (state_nxt == REQ_C);
            spi_stop_read     <= flush && (state != IDLE);
        end
    end

    // Next state: one word in flight at most, request only with a free entry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en) state_nxt = REQ_S;
            REQ_S:   state_nxt = WAIT;
            REQ_C:   state_nxt = WAIT;
            WAIT:    if (!spi_busy)
                         state_nxt = (fetch_en && (count_after < (PTR_W+1)'(FIFO_DEPTH))) ? REQ_C : HOLD;
            HOLD:    if (fetch_en && !full) state_nxt = REQ_C;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Prefetch FIFO storage and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= spi_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Fetch/consume address counters and replay slots; save samples cons_addr before this cycle's pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr <= '0;
            cons_addr  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
        end else begin
            if (clear_addr) begin
                fetch_addr <= '0;
                cons_addr  <= '0;
                for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
            end else if (load_eff) begin
                fetch_addr <= slot[slot_sel];
                cons_addr  <= slot[slot_sel];
            end else if (stop) begin
                fetch_addr <= cons_addr;
            end else begin
                if (push) fetch_addr <= fetch_addr + WAB'(1);
                if (pop)  cons_addr  <= cons_addr + WAB'(1);
            end
            if (save_addr && slot_ok) slot[slot_sel] <= cons_addr;
        end
    end

endmodule
